// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the instruction-memory request/response channel, the
// redirect input and the decoder-facing handshake of the fetch stage.
// master = fetch unit side, slave = memory / branch unit / decoder side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_addr, insn_valid, insn, insn_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, insn_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, insn_valid, insn, insn_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, insn_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues one word-aligned read at a time,
// buffers returned words with their PCs in a DEPTH-entry prefetch FIFO and
// hands them to the decoder over valid/ready. Redirects flush the FIFO and
// mark any in-flight response as stale.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- a redirect to a
// non-word-aligned PC raises a sticky fetch_fault and halts issue until the
// next aligned redirect. Without it the low PC bits of a redirect are dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          discard_q, discard_d;
  logic          fault_q, fault_d;
  logic [63:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          req_valid_s, req_fire_s, rsp_take_s, push_s, pop_s, insn_valid_s;
  logic          redir_bad_s;
  logic [31:0]   redirect_pc_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_bad_s   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redirect_pc_s = bus.redirect_pc;
`else
  assign redir_bad_s   = 1'b0;
  assign redirect_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  // Issue and handshake qualifiers; the request valid depends on registers only.
  assign insn_valid_s = (count_q != {CW{1'b0}});
  assign req_valid_s  = (state_q == S_IDLE) && (count_q < DEPTH_C) && !fault_q;
  assign req_fire_s   = req_valid_s && bus.imem_req_ready;
  assign rsp_take_s   = (state_q == S_WAIT) && bus.imem_rsp_valid;
  assign push_s       = rsp_take_s && !discard_q && !bus.redirect_valid;
  assign pop_s        = insn_valid_s && bus.insn_ready && !bus.redirect_valid;

  // Request FSM, PC tracking, stale-response and fault bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: if (req_fire_s) state_d = S_WAIT; else state_d = S_IDLE;
      S_WAIT: if (bus.imem_rsp_valid) state_d = S_IDLE; else state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (req_fire_s) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      req_pc_d   = req_pc_q;
    end
    if (rsp_take_s) begin
      discard_d = 1'b0;
    end else begin
      discard_d = discard_q;
    end
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_pc_s;
      fault_d    = redir_bad_s;
      // A request still in flight after this edge must have its word dropped.
      if (req_fire_s || ((state_q == S_WAIT) && !bus.imem_rsp_valid)) begin
        discard_d = 1'b1;
      end else begin
        discard_d = 1'b0;
      end
    end else begin
      fault_d = fault_q;
    end
  end

  // Prefetch FIFO pointer/occupancy update; a redirect empties the buffer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1'b1); else wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1'b1); else rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      discard_q  <= 1'b0;
      fault_q    <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      fault_q    <= fault_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: {instruction word, PC} written on accepted, non-stale responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 64'h0;
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= {bus.imem_rsp_data, req_pc_q};
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.insn_valid     = insn_valid_s;
  assign bus.insn           = fifo_q[rd_ptr_q][63:32];
  assign bus.insn_pc        = fifo_q[rd_ptr_q][31:0];
  assign bus.fetch_fault    = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a scoreboard. Stimulus
// pushes the expected {insn, pc} stream and request addresses; a monitor at
// the falling edge pops and compares on every insn and request handshake.
// Memory returns {16'hDEAD, addr[15:0]} after a configurable latency.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [63:0] exp_q[$];
  logic [31:0] exp_addr[$];
  int n_chk = 0;
  int n_fail = 0;
  int fire_cnt = 0;
  int mem_lat = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_insn(input logic [31:0] data, input logic [31:0] pc);
    exp_q.push_back({data, pc});
  endtask

  // Memory model: one request in flight, response after mem_lat cycles.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          wait_cnt;
    pend = 1'b0; pend_addr = 32'h0; wait_cnt = 0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.imem_rsp_valid = 1'b0;
      if (pend) begin
        if (wait_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = {16'hDEAD, pend_addr[15:0]};
          pend = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend = 1'b1;
        pend_addr = bus.imem_addr;
        wait_cnt = mem_lat - 1;
      end
    end
  end

  // Monitor: compares delivered instructions and issued addresses.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      if (bus.insn_valid && bus.insn_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_insn_pc", bus.insn_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("insn_pc", bus.insn_pc, e[31:0]);
          chk("insn", bus.insn, e[63:32]);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        fire_cnt++;
        if (exp_addr.size() != 0) chk("imem_addr", bus.imem_addr, exp_addr.pop_front());
      end
    end
  end

  task automatic do_reset(input logic rdy);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.insn_ready     = rdy;
    exp_q.delete();
    exp_addr.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    fire_cnt = 0;
    chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("rst_addr", bus.imem_addr, 32'h0000_0100);
    chk("rst_insn_valid", {31'h0, bus.insn_valid}, 32'h0);
    chk("rst_insn", bus.insn, 32'h0);
    chk("rst_insn_pc", bus.insn_pc, 32'h0);
    chk("rst_fault", {31'h0, bus.fetch_fault}, 32'h0);
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 80 && (exp_q.size() != 0 || exp_addr.size() != 0); i++) @(negedge clk);
    chk({name, "_pending"}, exp_q.size() + exp_addr.size(), 32'h0);
  endtask

  task automatic wait_fire(input logic [31:0] a);
    int i;
    bit hit;
    hit = 1'b0;
    for (i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = bus.imem_req_valid && bus.imem_req_ready && (bus.imem_addr == a);
    end
    chk("wait_fire_timeout", {31'h0, hit}, 32'h1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.insn_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Sequential fetch from RESET_PC.
    mem_lat = 1;
    do_reset(1'b1);
    exp_addr.push_back(32'h0000_0100); exp_addr.push_back(32'h0000_0104);
    exp_addr.push_back(32'h0000_0108);
    exp_insn(32'hDEAD_0100, 32'h0000_0100);
    exp_insn(32'hDEAD_0104, 32'h0000_0104);
    exp_insn(32'hDEAD_0108, 32'h0000_0108);
    drain("seq");

    // Decoder stalled: exactly DEPTH requests, then issue stops.
    do_reset(1'b0);
    exp_addr.push_back(32'h0000_0100); exp_addr.push_back(32'h0000_0104);
    repeat (12) @(negedge clk);
    chk("stall_fire_cnt", fire_cnt, 32'd2);
    chk("stall_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    chk("stall_head_pc", bus.insn_pc, 32'h0000_0100);
    exp_insn(32'hDEAD_0100, 32'h0000_0100);
    exp_insn(32'hDEAD_0104, 32'h0000_0104);
    exp_insn(32'hDEAD_0108, 32'h0000_0108);
    exp_insn(32'hDEAD_010C, 32'h0000_010C);
    @(posedge clk); #1;
    bus.insn_ready = 1'b1;
    drain("stall");

    // Memory not ready: address held at 0x104.
    do_reset(1'b1);
    exp_addr.push_back(32'h0000_0100); exp_addr.push_back(32'h0000_0104);
    exp_addr.push_back(32'h0000_0108);
    exp_insn(32'hDEAD_0100, 32'h0000_0100);
    exp_insn(32'hDEAD_0104, 32'h0000_0104);
    exp_insn(32'hDEAD_0108, 32'h0000_0108);
    @(posedge clk); #1;
    bus.imem_req_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, bus.imem_req_valid}, 32'h1);
      chk("hold_addr", bus.imem_addr, 32'h0000_0104);
      @(posedge clk); #1;
    end
    bus.imem_req_ready = 1'b1;
    drain("hold");

    // Redirect while 0x108 is outstanding: its word must be dropped.
    mem_lat = 2;
    do_reset(1'b1);
    exp_addr.push_back(32'h0000_0100); exp_addr.push_back(32'h0000_0104);
    exp_addr.push_back(32'h0000_0108); exp_addr.push_back(32'h0000_0200);
    exp_addr.push_back(32'h0000_0204);
    exp_insn(32'hDEAD_0100, 32'h0000_0100);
    exp_insn(32'hDEAD_0104, 32'h0000_0104);
    exp_insn(32'hDEAD_0200, 32'h0000_0200);
    exp_insn(32'hDEAD_0204, 32'h0000_0204);
    wait_fire(32'h0000_0108);
    @(posedge clk); #1;
    pulse_redirect(32'h0000_0200);
    drain("redir_wait");

    // Redirect in the same cycle as a response and a pop.
    mem_lat = 1;
    do_reset(1'b0);
    exp_addr.push_back(32'h0000_0100); exp_addr.push_back(32'h0000_0104);
    exp_addr.push_back(32'h0000_0300);
    exp_insn(32'hDEAD_0100, 32'h0000_0100);
    exp_insn(32'hDEAD_0300, 32'h0000_0300);
    exp_insn(32'hDEAD_0304, 32'h0000_0304);
    wait_fire(32'h0000_0104);
    @(posedge clk); #1;
    bus.insn_ready = 1'b1;
    pulse_redirect(32'h0000_0300);
    @(negedge clk);
    chk("redir_rsp_empty", {31'h0, bus.insn_valid}, 32'h0);
    chk("redir_rsp_req", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("redir_rsp_addr", bus.imem_addr, 32'h0000_0300);
    drain("redir_rsp");

    // Misaligned redirect.
    do_reset(1'b1);
    exp_addr.push_back(32'h0000_0100);
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_addr.push_back(32'h0000_0300); exp_addr.push_back(32'h0000_0304);
    exp_insn(32'hDEAD_0300, 32'h0000_0300);
    exp_insn(32'hDEAD_0304, 32'h0000_0304);
    @(posedge clk); #1;
    pulse_redirect(32'h0000_0202);
    @(negedge clk);
    chk("fault_set", {31'h0, bus.fetch_fault}, 32'h1);
    chk("fault_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
    chk("fault_empty", {31'h0, bus.insn_valid}, 32'h0);
    fire_cnt = 0;
    repeat (5) @(negedge clk);
    chk("fault_fire_cnt", fire_cnt, 32'd0);
    chk("fault_sticky", {31'h0, bus.fetch_fault}, 32'h1);
    @(posedge clk); #1;
    pulse_redirect(32'h0000_0300);
    @(negedge clk);
    chk("fault_clear", {31'h0, bus.fetch_fault}, 32'h0);
    chk("fault_resume_addr", bus.imem_addr, 32'h0000_0300);
`else
    exp_addr.push_back(32'h0000_0200); exp_addr.push_back(32'h0000_0204);
    exp_insn(32'hDEAD_0200, 32'h0000_0200);
    exp_insn(32'hDEAD_0204, 32'h0000_0204);
    @(posedge clk); #1;
    pulse_redirect(32'h0000_0202);
    @(negedge clk);
    chk("misalign_fault", {31'h0, bus.fetch_fault}, 32'h0);
    chk("misalign_req", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("misalign_addr", bus.imem_addr, 32'h0000_0200);
`endif
    drain("misalign");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
